// File: rtl/cdc_fifo_rd_stream_pkg.sv
// Shared helpers for the CDC FIFO read-side stream adapter: lane-index sizing
// and the supported width-ratio limit.
package cdc_fifo_rd_stream_pkg;

  localparam int unsigned MAX_RATIO = 16;
  localparam int unsigned CNT_W     = 2;

  // A lane index is at least one bit wide, even when a word has a single lane.
  function automatic int unsigned lane_w(input int unsigned ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/cdc_lane_mux.sv
// Combinational lane select: picks one OUT_DW slice of a word by lane index,
// walking from the LSB or the MSB end.
module cdc_lane_mux
  import cdc_fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned OUT_DW    = 16,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned LW        = 1,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic [DW-1:0]     slot_i,
  input  logic [LW-1:0]     lane_i,
  output logic [OUT_DW-1:0] lane_data_c
);

  logic [LW-1:0] sel;

  always_comb begin
    lane_data_c = '0;
    sel         = (LSB_FIRST != 0) ? lane_i : (LW'(RATIO - 1) - lane_i);
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sel == LW'(i)) lane_data_c = slot_i[i*OUT_DW +: OUT_DW];
    end
  end

endmodule

// File: rtl/cdc_fifo_rd_stream.sv
// Read-domain adapter after the CDC FIFO: pops words into a two-entry skid
// buffer and streams each word out as RATIO narrower lanes.
module cdc_fifo_rd_stream
  import cdc_fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned OUT_DW    = 16,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_rd_empty,
  input  logic [DW-1:0]     fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [OUT_DW-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        level
);

  localparam int unsigned RATIO = DW / OUT_DW;
  localparam int unsigned LW    = lane_w(RATIO);

  if (((DW % OUT_DW) != 0) || (RATIO < 1) || (RATIO > MAX_RATIO)) begin : g_bad_ratio
    $error("cdc_fifo_rd_stream: DW must be a multiple of OUT_DW with 1 <= DW/OUT_DW <= 16");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [DW-1:0]    slot0_q, slot0_d;
  logic [DW-1:0]    slot1_q, slot1_d;
  logic             xfer, lane_end, retire, fill;

  // Pop decision looks only at registered occupancy, never at out_ready.
  assign fill       = rst_n && !fifo_rd_empty && (count_q != 2'd2) && !flush;
  assign fifo_rd_en = fill;

  assign out_valid = (count_q != '0);
  assign lane_end  = (lane_q == LW'(RATIO - 1));
  assign out_last  = out_valid && lane_end;
  assign xfer      = out_valid && out_ready;
  assign retire    = xfer && lane_end;
  assign level     = count_q;

  always_comb begin
    count_d = count_q;
    lane_d  = lane_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      count_d = '0;
      lane_d  = '0;
    end else begin
      if (xfer) lane_d = lane_end ? '0 : LW'(lane_q + LW'(1));
      unique case (count_q)
        2'd0: begin
          if (fill) begin
            slot0_d = fifo_rd_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (fill && !retire) begin
            slot1_d = fifo_rd_data;
            count_d = 2'd2;
          end else if (fill && retire) begin
            slot0_d = fifo_rd_data;
          end else if (retire) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // Full: the pop is already blocked, so only a retire can move data.
          if (retire) begin
            slot0_d = slot1_q;
            count_d = 2'd1;
          end
        end
        default: count_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      lane_q  <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      lane_q  <= lane_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  cdc_lane_mux #(
    .DW       (DW),
    .OUT_DW   (OUT_DW),
    .RATIO    (RATIO),
    .LW       (LW),
    .LSB_FIRST(LSB_FIRST)
  ) u_lane_mux (
    .slot_i     (slot0_q),
    .lane_i     (lane_q),
    .lane_data_c(out_data)
  );

endmodule

// File: tb/tb_cdc_fifo_rd_stream.sv
// Directed bench: three adapter instances (LSB-first 32->16, MSB-first 32->16,
// and 8->8) each fed by a simple array-based FIFO model.
module tb_cdc_fifo_rd_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // FIFO models: pointers advance on the clock edge where the DUT pops.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [7:0]  mem_c [16];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, wr_c = 0, rd_c = 0;

  logic        empty_a, empty_b, empty_c;
  logic [31:0] fdata_a, fdata_b;
  logic [7:0]  fdata_c;
  logic        rden_a, rden_b, rden_c;
  logic        flush_a = 1'b0, flush_b = 1'b0, flush_c = 1'b0;
  logic        ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
  logic [15:0] data_a, data_b;
  logic [7:0]  data_c;
  logic        valid_a, valid_b, valid_c;
  logic        last_a, last_b, last_c;
  logic [1:0]  level_a, level_b, level_c;

  assign empty_a = (rd_a == wr_a);
  assign empty_b = (rd_b == wr_b);
  assign empty_c = (rd_c == wr_c);
  assign fdata_a = mem_a[rd_a[3:0]];
  assign fdata_b = mem_b[rd_b[3:0]];
  assign fdata_c = mem_c[rd_c[3:0]];

  always @(posedge clk) begin
    if (rden_a) rd_a <= rd_a + 1;
    if (rden_b) rd_b <= rd_b + 1;
    if (rden_c) rd_c <= rd_c + 1;
  end

  cdc_fifo_rd_stream #(.DW(32), .OUT_DW(16), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_rd_empty(empty_a), .fifo_rd_data(fdata_a),
    .fifo_rd_en(rden_a), .flush(flush_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_last(last_a), .level(level_a));

  cdc_fifo_rd_stream #(.DW(32), .OUT_DW(16), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_rd_empty(empty_b), .fifo_rd_data(fdata_b),
    .fifo_rd_en(rden_b), .flush(flush_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_last(last_b), .level(level_b));

  cdc_fifo_rd_stream #(.DW(8), .OUT_DW(8), .LSB_FIRST(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .fifo_rd_empty(empty_c), .fifo_rd_data(fdata_c),
    .fifo_rd_en(rden_c), .flush(flush_c), .out_data(data_c), .out_valid(valid_c),
    .out_ready(ready_c), .out_last(last_c), .level(level_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    mem_a[0] = 32'hAABB_CCDD; wr_a = 1;
    mem_b[0] = 32'hAABB_CCDD; wr_b = 1;

    // Reset held with non-empty FIFOs
    repeat (3) step();
    chk("rst_rden_a",  32'(rden_a),  32'd0);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_level_a", 32'(level_a), 32'd0);
    chk("rst_data_a",  32'(data_a),  32'd0);
    chk("rst_last_a",  32'(last_a),  32'd0);
    chk("rst_rden_b",  32'(rden_b),  32'd0);

    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_rden_a", 32'(rden_a), 32'd1);

    // LSB-first and MSB-first lane order, one stalled cycle first
    step();
    chk("pop_level_a", 32'(level_a), 32'd1);
    chk("pop_valid_a", 32'(valid_a), 32'd1);
    chk("pop_cnt_a",   32'(rd_a),    32'd1);
    chk("lsb_l0_a",    32'(data_a),  32'h0000_CCDD);
    chk("lsb_l0_last", 32'(last_a),  32'd0);
    chk("msb_l0_b",    32'(data_b),  32'h0000_AABB);
    chk("msb_l0_last", 32'(last_b),  32'd0);
    step();
    chk("hold_data_a", 32'(data_a), 32'h0000_CCDD);
    chk("hold_last_a", 32'(last_a), 32'd0);
    chk("hold_data_b", 32'(data_b), 32'h0000_AABB);
    ready_a = 1'b1; ready_b = 1'b1;
    step();
    chk("lsb_l1_a",    32'(data_a), 32'h0000_AABB);
    chk("lsb_l1_last", 32'(last_a), 32'd1);
    chk("msb_l1_b",    32'(data_b), 32'h0000_CCDD);
    chk("msb_l1_last", 32'(last_b), 32'd1);
    step();
    chk("ret_valid_a", 32'(valid_a), 32'd0);
    chk("ret_level_a", 32'(level_a), 32'd0);
    chk("ret_valid_b", 32'(valid_b), 32'd0);

    // Backpressure: three words queued, consumer stalled for five cycles
    ready_a = 1'b0; ready_b = 1'b0;
    base = rd_a;
    mem_a[1] = 32'h0102_0304; mem_a[2] = 32'h0506_0708; mem_a[3] = 32'h090A_0B0C;
    wr_a = 4;
    step(); step();
    chk("bp_data_c2", 32'(data_a), 32'h0000_0304);
    step(); step(); step();
    chk("bp_pops",    32'(rd_a - base), 32'd2);
    chk("bp_level",   32'(level_a), 32'd2);
    chk("bp_data_c5", 32'(data_a), 32'h0000_0304);
    chk("bp_rden",    32'(rden_a), 32'd0);
    ready_a = 1'b1;
    step();
    chk("bp_w0l1",     32'(data_a), 32'h0000_0102);
    chk("bp_w0l1_lst", 32'(last_a), 32'd1);
    chk("bp_w0l1_lvl", 32'(level_a), 32'd2);
    step();
    chk("bp_w1l0",     32'(data_a), 32'h0000_0708);
    chk("bp_w1l0_lvl", 32'(level_a), 32'd1);
    chk("bp_pops_pre", 32'(rd_a - base), 32'd2);
    step();
    chk("bp_w1l1",      32'(data_a), 32'h0000_0506);
    chk("bp_pops_post", 32'(rd_a - base), 32'd3);
    chk("bp_w1l1_lvl",  32'(level_a), 32'd2);
    step();
    chk("bp_w2l0", 32'(data_a), 32'h0000_0B0C);
    chk("bp_w2l0_vld", 32'(valid_a), 32'd1);
    step();
    chk("bp_w2l1",     32'(data_a), 32'h0000_090A);
    chk("bp_w2l1_lst", 32'(last_a), 32'd1);
    step();
    chk("bp_done_vld", 32'(valid_a), 32'd0);

    // Mid-word flush drops the rest of the word; next FIFO word follows
    base = rd_a;
    mem_a[4] = 32'h1111_2222; mem_a[5] = 32'h3333_4444;
    wr_a = 6;
    step();
    chk("fl_l0",   32'(data_a), 32'h0000_2222);
    chk("fl_rden", 32'(rden_a), 32'd1);
    flush_a = 1'b1; #1;
    chk("fl_nopop", 32'(rden_a), 32'd0);
    step();
    chk("fl_valid", 32'(valid_a), 32'd0);
    chk("fl_level", 32'(level_a), 32'd0);
    chk("fl_pops",  32'(rd_a - base), 32'd1);
    flush_a = 1'b0;
    step();
    chk("fl_n0",     32'(data_a), 32'h0000_4444);
    chk("fl_n0_lst", 32'(last_a), 32'd0);
    step();
    chk("fl_n1",     32'(data_a), 32'h0000_3333);
    chk("fl_n1_lst", 32'(last_a), 32'd1);
    step();
    chk("fl_end_vld", 32'(valid_a), 32'd0);

    // RATIO==1: one word per cycle after one cycle of fill latency
    ready_c = 1'b1;
    for (int i = 0; i < 10; i++) mem_c[i] = 8'(i);
    wr_c = 10;
    #1;
    chk("r1_pre_vld", 32'(valid_c), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("r1_data%0d", i), 32'(data_c), 32'(i));
      chk($sformatf("r1_vld%0d", i), 32'(valid_c), 32'd1);
      chk($sformatf("r1_lst%0d", i), 32'(last_c), 32'd1);
      chk($sformatf("r1_lvl%0d", i), 32'(level_c), 32'd1);
    end
    step();
    chk("r1_end_vld", 32'(valid_c), 32'd0);
    chk("r1_end_lvl", 32'(level_c), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
